uart_tx_stream: RTL and testbench

//  Parametrised UART transmitter: next generation of the fixed 8N1 serial TX.
//  - Configurable data width, bit period, stop bits; small input FIFO; valid/ready input.
//  - Back-to-back frames with no idle gap.
//  - Feeds the board serial line; upstream command/telemetry logic pushes bytes without polling.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_stream.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the streaming UART transmitter.
// The PARITY state exists in every build so state encodings stay stable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Read data is presented combinationally from the head entry.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Full/empty come straight from the registered count, so a same-cycle pop never opens space.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage has no reset; only pointers and count need a defined value, and leaving the array unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Parametrised UART transmitter with input FIFO and back-to-back framing.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 43,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TX,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_stream: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_e      state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                baud_end;
    logic                load;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != IDLE);
    assign TX       = tx_q;
    assign tx_done  = done_q;
    assign baud_end = (baud_q == BAUD_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = UART_IDLE_LVL;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        load     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        // tx_d is the level for the current state; registering it delays TX by one cycle.
        case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                tx_d = UART_START_LVL;
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (baud_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        load    = !fifo_empty;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared by IDLE and end-of-STOP so consecutive frames start with no idle gap.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            baud_d   = '0;
            bit_d    = '0;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            par_d    = (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LVL;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: one STOP_BITS=1 instance and one STOP_BITS=2 instance.
// Follows UART_TX_PARITY_EN so frame expectations include the parity bit when it is built in.
module tb_uart_tx_stream;

    localparam int CPB = 43;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_LEN = (1 + 8 + PBITS + 1) * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_valid1, tx_valid2;
    logic       tx_ready1, tx_ready2;
    logic       tx1, tx2;
    logic       busy1, busy2;
    logic       done1, done2;
    logic [2:0] count1, count2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_t[$];

    always #5 clk = ~clk;

    uart_tx_stream #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .TX(tx1), .tx_busy(busy1), .tx_done(done1), .fifo_count(count1)
    );

    uart_tx_stream #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .TX(tx2), .tx_busy(busy2), .tx_done(done2), .fifo_count(count2)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done1 === 1'b1) done_t.push_back(cyc);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_of(input int sel);
        return (sel != 0) ? tx2 : tx1;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? done2 : done1;
    endfunction

    // Expected serial bits, index 0 = start bit, LSB of data first.
    function automatic logic [15:0] frame_bits(input logic [7:0] data);
        logic [15:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = data[i];
`ifdef UART_TX_PARITY_EN
        b[9] = ^data;
`endif
        return b;
    endfunction

    task automatic push(input int sel, input logic [7:0] data);
        int w;
        if (sel != 0) begin tx_valid2 = 1'b1; tx_data2 = data; end
        else begin tx_valid1 = 1'b1; tx_data1 = data; end
        w = 0;
        while (((sel != 0) ? tx_ready2 : tx_ready1) !== 1'b1 && w < 3000) begin tick; w++; end
        total++;
        if (((sel != 0) ? tx_ready2 : tx_ready1) !== 1'b1) begin
            bad++;
            $display("FAIL push_%0d: tx_ready never rose, got %b required 1", sel, (sel != 0) ? tx_ready2 : tx_ready1);
        end
        tick;
        if (sel != 0) tx_valid2 = 1'b0; else tx_valid1 = 1'b0;
    endtask

    // Waits for a start bit, then checks TX and tx_done on every cycle of the frame.
    task automatic check_frame(input int sel, input logic [7:0] data, input int stop, input string name);
        int w, n, tx_err, done_err;
        logic [15:0] bits;
        logic exp_tx, exp_done, tx_got, tx_exp, done_got, done_exp;
        w = 0;
        while (line_of(sel) !== 1'b0 && w < 3000) begin tick; w++; end
        total++;
        if (line_of(sel) !== 1'b0) begin
            bad++;
            $display("FAIL %s start: TX got %b required 0 within 3000 cycles", name, line_of(sel));
            return;
        end
        n = (1 + 8 + PBITS + stop) * CPB;
        bits = frame_bits(data);
        tx_err = -1; done_err = -1;
        tx_got = 1'b0; tx_exp = 1'b0; done_got = 1'b0; done_exp = 1'b0;
        for (int c = 0; c < n; c++) begin
            exp_tx   = bits[c / CPB];
            exp_done = (c == n - 1);
            if (tx_err < 0 && line_of(sel) !== exp_tx) begin
                tx_err = c; tx_got = line_of(sel); tx_exp = exp_tx;
            end
            if (done_err < 0 && done_of(sel) !== exp_done) begin
                done_err = c; done_got = done_of(sel); done_exp = exp_done;
            end
            tick;
        end
        total++;
        if (tx_err >= 0) begin
            bad++;
            $display("FAIL %s TX at frame cycle %0d: got %b required %b", name, tx_err, tx_got, tx_exp);
        end
        total++;
        if (done_err >= 0) begin
            bad++;
            $display("FAIL %s tx_done at frame cycle %0d: got %b required %b", name, done_err, done_got, done_exp);
        end
    endtask

    task automatic test_reset;
        #20;
        total++; if (tx1 !== 1'b1)     begin bad++; $display("FAIL reset_tx: got %b required 1", tx1); end
        total++; if (busy1 !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b required 0", busy1); end
        total++; if (done1 !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b required 0", done1); end
        total++; if (count1 !== 3'd0)  begin bad++; $display("FAIL reset_count: got %0d required 0", count1); end
        total++; if (tx_ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", tx_ready1); end
        total++; if (tx2 !== 1'b1)     begin bad++; $display("FAIL reset_tx2: got %b required 1", tx2); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick; tick;
        total++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: TX=%b busy=%b required 1/0", tx1, busy1);
        end
    endtask

    task automatic test_single;
        push(0, 8'hA5);
        total++; if (busy1 !== 1'b0 || count1 !== 3'd1) begin
            bad++; $display("FAIL latency_k: busy=%b count=%0d required 0/1", busy1, count1);
        end
        tick;
        total++; if (busy1 !== 1'b1 || tx1 !== 1'b1) begin
            bad++; $display("FAIL latency_k1: busy=%b TX=%b required 1/1", busy1, tx1);
        end
        tick;
        total++; if (tx1 !== 1'b0) begin
            bad++; $display("FAIL latency_k2: TX got %b required 0", tx1);
        end
        check_frame(0, 8'hA5, 1, "single_a5");
    endtask

    task automatic test_back_to_back;
        done_t.delete();
        push(0, 8'h00);
        push(0, 8'hFF);
        check_frame(0, 8'h00, 1, "b2b_first");
        total++; if (tx1 !== 1'b0) begin
            bad++; $display("FAIL b2b_no_gap: TX got %b required 0", tx1);
        end
        check_frame(0, 8'hFF, 1, "b2b_second");
        total++;
        if (done_t.size() != 2) begin
            bad++; $display("FAIL b2b_done_count: got %0d required 2", done_t.size());
        end else if (done_t[1] - done_t[0] != FRAME_LEN) begin
            bad++; $display("FAIL b2b_done_spacing: got %0d required %0d", done_t[1] - done_t[0], FRAME_LEN);
        end
    endtask

    task automatic test_fifo_full;
        logic [7:0] w [6];
        int idx, saw_full, ready_err;
        logic acc;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
        idx = 0; saw_full = 0; ready_err = 0;
        fork
            begin
                tx_valid1 = 1'b1;
                tx_data1  = w[0];
                for (int c = 0; c < 100; c++) begin
                    acc = tx_valid1 && tx_ready1;
                    tick;
                    if (acc) begin
                        idx++;
                        if (idx < 6) tx_data1 = w[idx];
                        else tx_valid1 = 1'b0;
                    end
                    if (count1 == 3'd4) begin
                        saw_full = 1;
                        if (tx_ready1 !== 1'b0) ready_err++;
                    end
                end
                tx_valid1 = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) check_frame(0, w[i], 1, $sformatf("fifo_order_%0d", i));
            end
        join
        total++; if (idx != 5) begin bad++; $display("FAIL fifo_accepted: got %0d required 5", idx); end
        total++; if (saw_full != 1) begin bad++; $display("FAIL fifo_reached_full: got %0d required 1", saw_full); end
        total++; if (ready_err != 0) begin bad++; $display("FAIL fifo_ready_when_full: got %0d bad cycles required 0", ready_err); end
        total++; if (busy1 !== 1'b0 || count1 !== 3'd0) begin
            bad++; $display("FAIL fifo_drained: busy=%b count=%0d required 0/0", busy1, count1);
        end
    endtask

    task automatic test_two_stop;
        push(1, 8'h3C);
        check_frame(1, 8'h3C, 2, "two_stop_3c");
        total++; if (busy2 !== 1'b0 || tx2 !== 1'b1) begin
            bad++; $display("FAIL two_stop_idle: busy=%b TX=%b required 0/1", busy2, tx2);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        push(0, 8'hA5);
        push(0, 8'h07);
        check_frame(0, 8'hA5, 1, "parity_a5");
        check_frame(0, 8'h07, 1, "parity_07");
    endtask
`endif

    task automatic test_reset_mid_frame;
        int w, idle_err;
        done_t.delete();
        push(0, 8'hC3);
        push(0, 8'h96);
        push(0, 8'h69);
        w = 0;
        while (tx1 !== 1'b0 && w < 100) begin tick; w++; end
        // C3 sends data bit 2 (a 0) at frame cycles 129..171.
        repeat (3 * CPB + 10) tick;
        total++; if (tx1 !== 1'b0 || count1 !== 3'd2 || busy1 !== 1'b1) begin
            bad++; $display("FAIL midframe_pre: TX=%b count=%0d busy=%b required 0/2/1", tx1, count1, busy1);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL midreset_tx: got %b required 1", tx1); end
        total++; if (count1 !== 3'd0 || tx_ready1 !== 1'b1) begin
            bad++; $display("FAIL midreset_fifo: count=%0d ready=%b required 0/1", count1, tx_ready1);
        end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b required 0", busy1); end
        repeat (5) tick;
        rst_n = 1'b1;
        idle_err = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (tx1 !== 1'b1 || busy1 !== 1'b0) idle_err++;
        end
        total++; if (idle_err != 0) begin
            bad++; $display("FAIL midreset_flushed: got %0d non-idle cycles required 0", idle_err);
        end
        total++; if (done_t.size() != 0) begin
            bad++; $display("FAIL midreset_no_done: got %0d pulses required 0", done_t.size());
        end
        push(0, 8'h5A);
        check_frame(0, 8'h5A, 1, "after_reset_5a");
        total++; if (done_t.size() != 1) begin
            bad++; $display("FAIL after_reset_done: got %0d pulses required 1", done_t.size());
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
        tx_data1  = '0;
        tx_data2  = '0;
        #1 rst_n = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_fifo_full;
        test_two_stop;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
